object_reporter: RTL and testbench

Post-frame scheduler for the object data table. On each end-of-frame pulse it walks label IDs 1..num_labels, reads each entry's area and coordinate sums, and computes the integer centroid with one shared sequential divider. It emits one filtered record per object on a valid/ready stream. It sits after the connected-components stage and owns the table's `obj_id` read port while busy.

---
 rtl/object_reporter.sv | 155 +++++++++++++++
 tb/tb_object_reporter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_reporter.sv
// object_reporter: after each frame, walks the object table and computes integer
// centroids with one shared restoring divider. Filtered records go out on a valid/ready stream.
module object_reporter #(
  parameter int LOC_SIZE  = 16,
  parameter int LBL_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_done,
  input  logic [LBL_WIDTH-1:0] num_labels,
  input  logic [LOC_SIZE-1:0]  min_area,
  output logic [LBL_WIDTH-1:0] obj_id,
  input  logic [LOC_SIZE-1:0]  obj_area,
  input  logic [LOC_SIZE-1:0]  obj_x,
  input  logic [LOC_SIZE-1:0]  obj_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LBL_WIDTH-1:0] out_id,
  output logic [LOC_SIZE-1:0]  out_area,
  output logic [LOC_SIZE-1:0]  out_cx,
  output logic [LOC_SIZE-1:0]  out_cy,
  output logic                 busy,
  output logic                 done,
  output logic [LBL_WIDTH-1:0] report_count
);

  localparam int CW = $clog2(LOC_SIZE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOC_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, READ, DIV_X, DIV_Y, EMIT, NEXT, FINISH
  } state_t;

  state_t state, state_next, scan_first;

  logic [LBL_WIDTH-1:0] last_id;
  logic                 pending;
  logic [LOC_SIZE-1:0]  div_rem, div_quo, div_den, y_sum, cx_q;
  logic [CW-1:0]        div_cnt;

  logic [LOC_SIZE:0]    trial;
  logic [LOC_SIZE-1:0]  diff, step_rem, step_quo;
  logic                 ge, div_last, keep, start_scan;

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    trial    = {div_rem, div_quo[LOC_SIZE-1]};
    ge       = (trial >= {1'b0, div_den});
    diff     = trial[LOC_SIZE-1:0] - div_den;
    step_rem = ge ? diff : trial[LOC_SIZE-1:0];
    step_quo = {div_quo[LOC_SIZE-2:0], ge};
  end

  assign div_last   = (div_cnt == CNT_LAST);
  assign keep       = (obj_area != '0) && (obj_area >= min_area);
  assign start_scan = ((state == IDLE) && frame_done) ||
                      ((state == FINISH) && (pending || frame_done));
  // An empty frame passes through NEXT, so done lands two cycles after frame_done.
  assign scan_first = (num_labels == '0) ? NEXT : ADDR;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (frame_done) state_next = scan_first;
      ADDR:    state_next = READ;
      READ:    state_next = keep ? DIV_X : NEXT;
      DIV_X:   if (div_last) state_next = DIV_Y;
      DIV_Y:   if (div_last) state_next = EMIT;
      EMIT:    if (out_ready) state_next = NEXT;
      NEXT:    state_next = (obj_id == last_id) ? FINISH : ADDR;
      FINISH:  state_next = start_scan ? scan_first : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE) && (state != FINISH);
  assign done      = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      obj_id       <= '0;
      last_id      <= '0;
      pending      <= 1'b0;
      report_count <= '0;
      out_id       <= '0;
      out_area     <= '0;
      out_cx       <= '0;
      out_cy       <= '0;
      div_rem      <= '0;
      div_quo      <= '0;
      div_den      <= '0;
      div_cnt      <= '0;
      y_sum        <= '0;
      cx_q         <= '0;
    end else begin
      if (start_scan) begin
        last_id      <= num_labels;
        report_count <= '0;
        obj_id       <= (num_labels == '0) ? '0 : LBL_WIDTH'(1);
        pending      <= 1'b0;
      end else if (frame_done && busy) begin
        pending <= 1'b1;
      end

      unique case (state)
        READ: begin
          div_den <= obj_area;
          div_quo <= obj_x;
          div_rem <= '0;
          div_cnt <= '0;
          y_sum   <= obj_y;
        end
        DIV_X: begin
          // The last x step also reloads the divider with the y sum.
          if (div_last) begin
            cx_q    <= step_quo;
            div_quo <= y_sum;
            div_rem <= '0;
            div_cnt <= '0;
          end else begin
            div_quo <= step_quo;
            div_rem <= step_rem;
            div_cnt <= div_cnt + CW'(1);
          end
        end
        DIV_Y: begin
          div_quo <= step_quo;
          div_rem <= step_rem;
          div_cnt <= div_cnt + CW'(1);
          if (div_last) begin
            out_id   <= obj_id;
            out_area <= div_den;
            out_cx   <= cx_q;
            out_cy   <= step_quo;
          end
        end
        EMIT: begin
          if (out_ready && (report_count != '1))
            report_count <= report_count + LBL_WIDTH'(1);
        end
        NEXT: begin
          if (obj_id != last_id) obj_id <= obj_id + LBL_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_object_reporter.sv
// tb_object_reporter: drives table scans against a behavioural table/record model
// and checks records, timing, backpressure, pending restart and reset behaviour.
module tb_object_reporter;

  localparam int LOC = 16;
  localparam int LBL = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           frame_done = 1'b0;
  logic [LBL-1:0] num_labels = '0;
  logic [LOC-1:0] min_area = '0;
  logic [LBL-1:0] obj_id;
  logic [LOC-1:0] obj_area, obj_x, obj_y;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [LBL-1:0] out_id;
  logic [LOC-1:0] out_area, out_cx, out_cy;
  logic           busy, done;
  logic [LBL-1:0] report_count;

  always #5 clk = ~clk;

  object_reporter #(.LOC_SIZE(LOC), .LBL_WIDTH(LBL)) dut (
    .clk(clk), .reset(reset), .frame_done(frame_done), .num_labels(num_labels),
    .min_area(min_area), .obj_id(obj_id), .obj_area(obj_area), .obj_x(obj_x),
    .obj_y(obj_y), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_area(out_area), .out_cx(out_cx), .out_cy(out_cy), .busy(busy),
    .done(done), .report_count(report_count)
  );

  typedef struct packed {
    logic [LBL-1:0] id;
    logic [LOC-1:0] area;
    logic [LOC-1:0] cx;
    logic [LOC-1:0] cy;
  } rec_t;

  logic [LOC-1:0] tbl_area [256];
  logic [LOC-1:0] tbl_x    [256];
  logic [LOC-1:0] tbl_y    [256];
  rec_t got_q[$];
  rec_t exp_q[$];
  int   cyc = 0;
  int   done_count = 0;
  int   last_done_cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   seen_id [256];
  bit   zero_seen = 1'b0;

  // Table memory with one cycle of read latency.
  always @(posedge clk) begin
    obj_area <= tbl_area[obj_id];
    obj_x    <= tbl_x[obj_id];
    obj_y    <= tbl_y[obj_id];
    cyc      <= cyc + 1;
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_id, out_area, out_cx, out_cy});
    if (done) begin
      done_count++;
      last_done_cyc = cyc;
    end
    if (busy) begin
      seen_id[obj_id] = 1'b1;
      if (obj_id == '0) zero_seen = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_table();
    for (int i = 0; i < 256; i++) begin
      tbl_area[i] = '0;
      tbl_x[i]    = '0;
      tbl_y[i]    = '0;
    end
  endtask

  task automatic pulse_frame(output int fd);
    frame_done = 1'b1;
    fd = cyc;
    step();
    frame_done = 1'b0;
  endtask

  // Bounded wait for the done counter; an expired budget counts as a failure.
  task automatic wait_done(input int target, input int budget, input bit rand_ready);
    int k = 0;
    while (done_count < target && k < budget) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (done_count < target) begin
      n_fail++;
      $display("[TB] FAIL wait_done: done pulses %0d, required %0d", done_count, target);
    end
  endtask

  // Reference: every label 1..n whose area is nonzero and not below min gives one record.
  task automatic build_expected(input int n, input int min);
    rec_t r;
    for (int i = 1; i <= n; i++) begin
      if (tbl_area[i] != 0 && int'(tbl_area[i]) >= min) begin
        r.id   = LBL'(i);
        r.area = tbl_area[i];
        r.cx   = tbl_x[i] / tbl_area[i];
        r.cy   = tbl_y[i] / tbl_area[i];
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    steps(3);
    n_cmp++; if (obj_id !== '0)       begin n_fail++; $display("[TB] FAIL reset_obj_id: got %0d, expected 0", obj_id); end
    n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_out_valid: got %0d, expected 0", out_valid); end
    n_cmp++; if ({out_id, out_area, out_cx, out_cy} !== '0)
      begin n_fail++; $display("[TB] FAIL reset_out_fields: got %h, expected 0", {out_id, out_area, out_cx, out_cy}); end
    n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("[TB] FAIL reset_busy: got %0d, expected 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_fail++; $display("[TB] FAIL reset_done: got %0d, expected 0", done); end
    n_cmp++; if (report_count !== '0) begin n_fail++; $display("[TB] FAIL reset_report_count: got %0d, expected 0", report_count); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int fd, base;
    rec_t want;
    clear_table();
    tbl_area[1] = 16'd4; tbl_x[1] = 16'd40; tbl_y[1] = 16'd20;
    num_labels = 8'd1; min_area = 16'd1; out_ready = 1'b1;
    got_q.delete();
    base = done_count;
    pulse_frame(fd);
    n_cmp++; if (obj_id !== 8'd1) begin n_fail++; $display("[TB] FAIL single_obj_id_c1: got %0d, expected 1", obj_id); end
    n_cmp++; if (busy !== 1'b1)   begin n_fail++; $display("[TB] FAIL single_busy_c1: got %0d, expected 1", busy); end
    wait_done(base + 1, 200, 1'b0);
    n_cmp++; if (last_done_cyc - fd != 37)
      begin n_fail++; $display("[TB] FAIL single_done_latency: got %0d, expected 37", last_done_cyc - fd); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_done_width: got %0d, expected 0", done); end
    want = {8'd1, 16'd4, 16'd10, 16'd5};
    n_cmp++; if (got_q.size() != 1)
      begin n_fail++; $display("[TB] FAIL single_count: got %0d records, expected 1", got_q.size()); end
    else if (got_q[0] !== want)
      begin n_fail++; $display("[TB] FAIL single_record: got %h, expected %h", got_q[0], want); end
    n_cmp++; if (report_count !== 8'd1)
      begin n_fail++; $display("[TB] FAIL single_report_count: got %0d, expected 1", report_count); end
  endtask

  task automatic test_filter();
    int fd, base;
    clear_table();
    tbl_area[1] = 16'd0; tbl_x[1] = 16'd0;   tbl_y[1] = LOC'($urandom_range(0, 999));
    tbl_area[2] = 16'd2; tbl_x[2] = 16'd7;   tbl_y[2] = LOC'($urandom_range(0, 999));
    tbl_area[3] = 16'd9; tbl_x[3] = 16'd100; tbl_y[3] = LOC'($urandom_range(0, 999));
    num_labels = 8'd3; min_area = 16'd3;
    got_q.delete(); exp_q.delete();
    build_expected(3, 3);
    base = done_count;
    pulse_frame(fd);
    wait_done(base + 1, 300, 1'b0);
    n_cmp++; if (got_q.size() != exp_q.size())
      begin n_fail++; $display("[TB] FAIL filter_count: got %0d records, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++; if (got_q[i] !== exp_q[i])
        begin n_fail++; $display("[TB] FAIL filter_record[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0].cx !== 16'd11)
        begin n_fail++; $display("[TB] FAIL filter_cx: got %0d, expected 11", got_q[0].cx); end
    end
    n_cmp++; if (report_count !== 8'd1)
      begin n_fail++; $display("[TB] FAIL filter_report_count: got %0d, expected 1", report_count); end
  endtask

  task automatic test_random();
    int fd, base, n, min;
    for (int it = 0; it < 6; it++) begin
      clear_table();
      n   = $urandom_range(1, 8);
      min = $urandom_range(0, 12);
      for (int i = 1; i <= n; i++) begin
        tbl_area[i] = ($urandom_range(0, 3) == 0) ? LOC'($urandom) : LOC'($urandom_range(0, 20));
        tbl_x[i]    = LOC'($urandom);
        tbl_y[i]    = LOC'($urandom);
      end
      num_labels = LBL'(n); min_area = LOC'(min);
      got_q.delete(); exp_q.delete();
      build_expected(n, min);
      base = done_count;
      pulse_frame(fd);
      wait_done(base + 1, 3000, 1'b1);
      n_cmp++; if (got_q.size() != exp_q.size())
        begin n_fail++; $display("[TB] FAIL random%0d_count: got %0d records, expected %0d", it, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        n_cmp++; if (got_q[i] !== exp_q[i])
          begin n_fail++; $display("[TB] FAIL random%0d_record[%0d]: got %h, expected %h", it, i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (int'(report_count) != exp_q.size())
        begin n_fail++; $display("[TB] FAIL random%0d_report_count: got %0d, expected %0d", it, report_count, exp_q.size()); end
    end
  endtask

  task automatic test_backpressure();
    int fd, base, k;
    logic [55:0] held;
    clear_table();
    tbl_area[1] = 16'd3; tbl_x[1] = 16'd50; tbl_y[1] = 16'd31;
    num_labels = 8'd1; min_area = 16'd1;
    got_q.delete(); exp_q.delete();
    build_expected(1, 1);
    out_ready = 1'b0;
    base = done_count;
    pulse_frame(fd);
    k = 0;
    while (!out_valid && k < 100) begin step(); k++; end
    n_cmp++; if (out_valid !== 1'b1)
      begin n_fail++; $display("[TB] FAIL bp_valid_rise: got %0d, expected 1", out_valid); end
    held = {out_id, out_area, out_cx, out_cy};
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || {out_id, out_area, out_cx, out_cy} !== held || obj_id !== 8'd1)
        begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got valid %0d rec %h id %0d, expected valid 1 rec %h id 1",
                                 c, out_valid, {out_id, out_area, out_cx, out_cy}, obj_id, held); end
    end
    n_cmp++; if (got_q.size() != 0)
      begin n_fail++; $display("[TB] FAIL bp_no_accept: got %0d records, expected 0", got_q.size()); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0)
      begin n_fail++; $display("[TB] FAIL bp_valid_drop: got %0d, expected 0", out_valid); end
    wait_done(base + 1, 100, 1'b0);
    n_cmp++; if (got_q.size() != 1)
      begin n_fail++; $display("[TB] FAIL bp_count: got %0d records, expected 1", got_q.size()); end
    else if (got_q[0] !== exp_q[0])
      begin n_fail++; $display("[TB] FAIL bp_record: got %h, expected %h", got_q[0], exp_q[0]); end
  endtask

  task automatic test_empty();
    int fd, base;
    num_labels = 8'd0;
    got_q.delete();
    base = done_count;
    pulse_frame(fd);
    wait_done(base + 1, 20, 1'b0);
    n_cmp++; if (last_done_cyc - fd != 2)
      begin n_fail++; $display("[TB] FAIL empty_done_latency: got %0d, expected 2", last_done_cyc - fd); end
    n_cmp++; if (got_q.size() != 0 || report_count !== 8'd0)
      begin n_fail++; $display("[TB] FAIL empty_records: got %0d records count %0d, expected 0 and 0", got_q.size(), report_count); end
  endtask

  task automatic test_pending();
    int fd, base;
    clear_table();
    for (int i = 1; i <= 2; i++) begin
      tbl_area[i] = LOC'($urandom_range(1, 300));
      tbl_x[i]    = LOC'($urandom);
      tbl_y[i]    = LOC'($urandom);
    end
    num_labels = 8'd2; min_area = 16'd1;
    got_q.delete(); exp_q.delete();
    build_expected(2, 1);
    build_expected(2, 1);
    base = done_count;
    pulse_frame(fd);
    steps(5);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    steps(4);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    wait_done(base + 1, 300, 1'b0);
    n_cmp++; if (last_done_cyc - fd != 73)
      begin n_fail++; $display("[TB] FAIL pend_first_latency: got %0d, expected 73", last_done_cyc - fd); end
    n_cmp++; if (busy !== 1'b1 || obj_id !== 8'd1)
      begin n_fail++; $display("[TB] FAIL pend_restart: got busy %0d id %0d, expected busy 1 id 1", busy, obj_id); end
    wait_done(base + 2, 300, 1'b0);
    steps(150);
    n_cmp++; if (done_count != base + 2)
      begin n_fail++; $display("[TB] FAIL pend_scan_count: got %0d scans, expected 2", done_count - base); end
    n_cmp++; if (got_q.size() != exp_q.size())
      begin n_fail++; $display("[TB] FAIL pend_count: got %0d records, expected %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++; if (got_q[i] !== exp_q[i])
        begin n_fail++; $display("[TB] FAIL pend_record[%0d]: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (report_count !== 8'd2)
      begin n_fail++; $display("[TB] FAIL pend_report_count: got %0d, expected 2", report_count); end
  endtask

  task automatic test_wrap();
    int fd, base, nseen;
    clear_table();
    foreach (seen_id[i]) seen_id[i] = 1'b0;
    zero_seen = 1'b0;
    num_labels = 8'd255; min_area = 16'd1;
    got_q.delete();
    base = done_count;
    pulse_frame(fd);
    wait_done(base + 1, 2000, 1'b0);
    nseen = 0;
    for (int i = 1; i < 256; i++) if (seen_id[i]) nseen++;
    n_cmp++; if (nseen != 255 || zero_seen)
      begin n_fail++; $display("[TB] FAIL wrap_ids: got %0d ids zero %0d, expected 255 ids zero 0", nseen, zero_seen); end
    n_cmp++; if (last_done_cyc - fd != 766)
      begin n_fail++; $display("[TB] FAIL wrap_done_latency: got %0d, expected 766", last_done_cyc - fd); end
    n_cmp++; if (got_q.size() != 0)
      begin n_fail++; $display("[TB] FAIL wrap_records: got %0d, expected 0", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    int fd, base;
    clear_table();
    tbl_area[1] = 16'd5; tbl_x[1] = 16'd1000; tbl_y[1] = 16'd777;
    num_labels = 8'd1; min_area = 16'd1;
    got_q.delete(); exp_q.delete();
    base = done_count;
    pulse_frame(fd);
    steps(19);
    reset = 1'b1;
    step();
    n_cmp++; if ({obj_id, out_valid, out_id, out_area, out_cx, out_cy, busy, done, report_count} !== '0)
      begin n_fail++; $display("[TB] FAIL rmid_outputs: got id %0d valid %0d rec %h busy %0d done %0d count %0d, expected all 0",
                               obj_id, out_valid, {out_id, out_area, out_cx, out_cy}, busy, done, report_count); end
    reset = 1'b0;
    steps(3);
    n_cmp++; if (done_count != base || got_q.size() != 0)
      begin n_fail++; $display("[TB] FAIL rmid_no_done: got %0d done %0d records, expected 0 and 0", done_count - base, got_q.size()); end
    build_expected(1, 1);
    pulse_frame(fd);
    wait_done(base + 1, 200, 1'b0);
    n_cmp++; if (last_done_cyc - fd != 37)
      begin n_fail++; $display("[TB] FAIL rmid_rescan_latency: got %0d, expected 37", last_done_cyc - fd); end
    n_cmp++; if (got_q.size() != 1)
      begin n_fail++; $display("[TB] FAIL rmid_count: got %0d records, expected 1", got_q.size()); end
    else if (got_q[0] !== exp_q[0])
      begin n_fail++; $display("[TB] FAIL rmid_record: got %h, expected %h", got_q[0], exp_q[0]); end
  endtask

  initial begin
    clear_table();
    test_reset();
    test_single();
    test_filter();
    test_random();
    test_backpressure();
    test_empty();
    test_pending();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
